// File: rtl/fifo_rr_read_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_read_arbiter
//
// Round-robin read scheduler that lets NumPorts packet FIFOs share one
// downstream consumer. One entry is moved per transaction:
//   IDLE -> READ -> WAIT -> SEND (valid entry)
//   IDLE -> READ -> WAIT -> IDLE (entry with valid bit clear, dropped)
// The FIFOs present a registered buf_out, so the entry popped in READ is
// sampled one cycle later in WAIT.
//
// Output handshake: out_valid/out_ready follow strict valid/ready rules.
// Once out_valid is high, out_data and out_port stay stable and out_valid
// stays high until the cycle in which out_ready is also high; that cycle is
// the transfer. out_valid never depends combinationally on out_ready.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   fifo_empty   in   [NumPorts]            buf_empty of each FIFO
//   fifo_data    in   [NumPorts*DataWidth]  buf_out of each FIFO, port k at
//                                           [k*DataWidth +: DataWidth]
//   fifo_rd_en   out  [NumPorts]            one-hot pop strobe, high in READ only
//   out_data     out  [DataWidth]           captured entry
//   out_valid    out                        out_data holds a packet
//   out_ready    in                         consumer accepts out_data
//   out_port     out  [PortIdxWidth]        source port of out_data
//   drop_count   out  [DropCntWidth]        saturating count of dropped entries
//   busy         out                        high in every state except IDLE
//   state_dbg    out  [2]                   current FSM state (0 IDLE, 1 READ,
//                                           2 WAIT, 3 SEND)
// -----------------------------------------------------------------------------
module fifo_rr_read_arbiter #(
    parameter int NumPorts     = 4,
    parameter int PortIdxWidth = 2,
    parameter int DataWidth    = 67,
    parameter int ValidBitPos  = 63,
    parameter int DropCntWidth = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumPorts-1:0]           fifo_empty,
    input  logic [NumPorts*DataWidth-1:0] fifo_data,
    output logic [NumPorts-1:0]           fifo_rd_en,
    output logic [DataWidth-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PortIdxWidth-1:0]       out_port,
    output logic [DropCntWidth-1:0]       drop_count,
    output logic                          busy,
    output logic [1:0]                    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [PortIdxWidth-1:0] grant;       // port owning the current transaction
    logic [PortIdxWidth-1:0] last_grant;  // most recently popped port
    logic [PortIdxWidth-1:0] rr_pick;     // next port in round-robin order
    logic [PortIdxWidth-1:0] cand;
    logic                    any_req;

    logic [DataWidth-1:0]    port_entry [NumPorts];
    logic [DataWidth-1:0]    sel_entry;
    logic                    entry_valid;

    // -------------------------------------------------------------------------
    // Split the flat buf_out bus into one entry per port.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NumPorts; k++) begin : g_slice
        assign port_entry[k] = fifo_data[k*DataWidth +: DataWidth];
    end

    assign sel_entry   = port_entry[grant];
    assign entry_valid = sel_entry[ValidBitPos];

    // -------------------------------------------------------------------------
    // Round-robin search: scan last_grant+1, +2, ... wrapping modulo NumPorts.
    // The last candidate examined is last_grant itself, so a lone requester
    // is always found. The modulo keeps non-power-of-two port counts correct.
    // -------------------------------------------------------------------------
    always_comb begin
        rr_pick = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NumPorts; i++) begin
            cand = PortIdxWidth'((int'(last_grant) + i) % NumPorts);
            if (!any_req && !fifo_empty[cand]) begin
                any_req = 1'b1;
                rr_pick = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic. Ports becoming non-empty outside IDLE are only
    // looked at once the machine returns to IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // Invalid entries are dropped and do not occupy the output.
                state_nxt = entry_valid ? SEND : IDLE;
            end
            SEND: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pop strobe: decoded from state and grant, so it is a single-cycle
    // one-hot pulse that cannot outlive READ.
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_rd_en = '0;
        if (state == READ) begin
            fifo_rd_en = {{(NumPorts-1){1'b0}}, 1'b1} << grant;
        end
    end

    // -------------------------------------------------------------------------
    // Grant bookkeeping. last_grant resets to the highest port so that port 0
    // wins the first arbitration after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= PortIdxWidth'(NumPorts - 1);
        end else begin
            if (state == IDLE && any_req) begin
                grant <= rr_pick;
            end
            if (state == READ) begin
                last_grant <= grant;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output capture and drop counter. out_data is left untouched when the
    // transfer completes; only out_valid drops.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_port   <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (entry_valid) begin
                        out_data  <= sel_entry;
                        out_port  <= grant;
                        out_valid <= 1'b1;
                    end else if (drop_count != {DropCntWidth{1'b1}}) begin
                        drop_count <= drop_count + DropCntWidth'(1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_rr_read_arbiter (NumPorts = 4, 67-bit entries).
// A behavioural FIFO per port (queue + registered buf_out + registered empty
// flag) feeds the DUT. Pushing an entry also queues the expected pop strobe
// and, for entries with bit 63 set, the expected output {port, entry}; callers
// push in the order the round-robin arbiter is expected to grant.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_rr_read_arbiter;

    localparam int NP = 4;
    localparam int W  = 67;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // DUT signals
    logic [NP-1:0]   fifo_empty = '1;
    logic [NP*W-1:0] fifo_data  = '0;
    logic [NP-1:0]   fifo_rd_en;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [1:0]      out_port;
    logic [7:0]      drop_count;
    logic            busy;
    logic [1:0]      state_dbg;

    fifo_rr_read_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port),
        .drop_count (drop_count),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // scoreboard state
    int            tests = 0;
    int            fails = 0;
    logic [W+1:0]  exp_q[$];      // {port, entry}
    logic [NP-1:0] exp_rd_q[$];
    int            rd_cycles[$];
    int            valid_cycle = -1;
    logic          prev_valid = 1'b0;
    logic [W+1:0]  mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // behavioural FIFOs
    logic [W-1:0]  fifo_q[NP][$];
    logic [NP-1:0] pop_req = '0;

    always @(negedge clk) pop_req = fifo_rd_en;

    always @(posedge clk) begin
        for (int k = 0; k < NP; k++) begin
            if (pop_req[k] && fifo_q[k].size() > 0) begin
                fifo_data[k*W +: W] <= fifo_q[k].pop_front();
            end
            fifo_empty[k] <= (fifo_q[k].size() == 0);
        end
    end

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en != '0) begin
                rd_cycles.push_back(cycle);
                if (exp_rd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_en_unexpected: got %b expected none", fifo_rd_en);
                end else begin
                    check("rd_en", fifo_rd_en, exp_rd_q.pop_front());
                end
            end
            if (out_valid && !prev_valid) valid_cycle = cycle;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got port %0d data %0h expected none", out_port, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e[W-1:0]);
                    check("out_port", out_port, mon_e[W+1:W]);
                end
            end
        end
        prev_valid = out_valid;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input int port, input logic [W-1:0] d, input bit keep);
        fifo_q[port].push_back(d);
        exp_rd_q.push_back(4'b0001 << port);
        if (keep && d[63]) exp_q.push_back({2'(port), d});
    endtask

    function automatic bit drained();
        bit e = 1'b1;
        for (int k = 0; k < NP; k++) if (fifo_q[k].size() != 0) e = 1'b0;
        return e && (fifo_empty == '1) && !busy && exp_rd_q.size() == 0 && exp_q.size() == 0;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got still busy after %0d cycles expected drained", name, n);
        end
    endtask

    task automatic wait_neg(input string name, input int budget, input int what);
        // what: 0 = fifo_empty[2] low, 1 = out_valid high, 2 = state WAIT
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (what)
                0: hit = !fifo_empty[2];
                1: hit = out_valid;
                default: hit = (state_dbg == 2'd2);
            endcase
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no event in %0d cycles expected event", name, n);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        int t0;
        int rel;

        // reset state
        do_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 67'h0);
        check("rst_out_port", out_port, 2'd0);
        check("rst_drop", drop_count, 8'h00);
        check("rst_rd_en", fifo_rd_en, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, 2'd0);

        // 1: single port 2, latency
        rd_cycles.delete();
        push(2, 67'h0_8000_0000_0000_1234, 1'b1);
        wait_neg("t1_empty", 10, 0);
        t0 = cycle;
        drain("t1", 20);
        check("t1_rd_count", rd_cycles.size(), 1);
        if (rd_cycles.size() > 0) check("t1_rd_latency", rd_cycles[0] - t0, 1);
        check("t1_valid_latency", valid_cycle - t0, 3);

        // 2: all ports, fairness and spacing
        do_reset();
        rd_cycles.delete();
        push(0, 67'h5_8000_0000_0000_0A00, 1'b1);
        push(1, 67'h1_8000_0000_0000_0B01, 1'b1);
        push(2, 67'h2_8000_0000_0000_0C02, 1'b1);
        push(3, 67'h7_8000_0000_0000_0D03, 1'b1);
        push(0, 67'h3_8000_0000_0000_0E04, 1'b1);
        drain("t2", 60);
        check("t2_rd_count", rd_cycles.size(), 5);
        for (int i = 1; i < rd_cycles.size(); i++)
            check("t2_rd_spacing", rd_cycles[i] - rd_cycles[i-1], 4);

        // 3: invalid entry dropped
        check("t3_drop_before", drop_count, 8'h00);
        tick();
        push(1, 67'h6_0000_0000_0000_00AB, 1'b1);
        drain("t3", 20);
        check("t3_drop_after", drop_count, 8'h01);
        check("t3_state", state_dbg, 2'd0);
        check("t3_out_valid", out_valid, 1'b0);

        // 4: back-pressure in SEND
        tick();
        out_ready = 1'b0;
        push(3, 67'h4_8000_0000_0000_4444, 1'b1);
        push(0, 67'h2_8000_0000_0000_5555, 1'b1);
        wait_neg("t4_valid", 20, 1);
        for (int j = 0; j < 10; j++) begin
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_data", out_data, 67'h4_8000_0000_0000_4444);
            check("t4_hold_port", out_port, 2'd3);
            check("t4_hold_rd_en", fifo_rd_en, 4'b0000);
            @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        rel = cycle;
        rd_cycles.delete();
        drain("t4", 30);
        check("t4_next_rd_count", rd_cycles.size(), 1);
        if (rd_cycles.size() > 0) check("t4_next_rd_delay", rd_cycles[0] - rel, 2);

        // 5: drop counter saturation
        tick();
        for (int i = 0; i < 300; i++) push(0, 67'(i), 1'b1);
        drain("t5", 2000);
        check("t5_drop_sat", drop_count, 8'hFF);

        // 6: reset in WAIT, then port 0 first
        tick();
        push(0, 67'h1_8000_0000_0000_6666, 1'b0);
        wait_neg("t6_wait", 20, 2);
        #1 rst = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_out_data", out_data, 67'h0);
        check("t6_out_port", out_port, 2'd0);
        check("t6_drop", drop_count, 8'h00);
        check("t6_rd_en", fifo_rd_en, 4'b0000);
        check("t6_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        push(0, 67'h2_8000_0000_0000_7070, 1'b1);
        push(1, 67'h3_8000_0000_0000_7171, 1'b1);
        drain("t6", 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
